pwm_ramp_ctrl: RTL and testbench

Duty-cycle sequencer placed between the pwm_dc AXI4-Lite register file and the PWM generator core. It converts software-written target duty and direction into a rate-limited applied duty. It enforces ramp-down and dead time on direction reversal, and provides an immediate emergency stop. The register file drives the target and config inputs; the PWM core consumes the duty, direction and enable outputs.

---
 rtl/pwm_ramp_ctrl_if.sv | 29 ++
 rtl/pwm_ramp_ctrl.sv | 159 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_if.sv
// Control/status bundle between the pwm_dc register file (master) and the
// duty-cycle sequencer (slave).
interface pwm_ramp_ctrl_if #(
    parameter int unsigned DUTY_W = 16,
    parameter int unsigned DIV_W  = 16
);
    logic              enable;
    logic              estop;
    logic [DUTY_W-1:0] target_duty;
    logic              target_dir;
    logic [DUTY_W-1:0] cfg_step;
    logic [DIV_W-1:0]  cfg_div;
    logic [DUTY_W-1:0] duty_out;
    logic              dir_out;
    logic              pwm_en;
    logic              busy;
    logic              at_target;
    logic [2:0]        state;

    modport master (
        output enable, estop, target_duty, target_dir, cfg_step, cfg_div,
        input  duty_out, dir_out, pwm_en, busy, at_target, state
    );

    modport slave (
        input  enable, estop, target_duty, target_dir, cfg_step, cfg_div,
        output duty_out, dir_out, pwm_en, busy, at_target, state
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: rate-limits the applied PWM duty toward the software
// target, ramps to zero and inserts dead time on direction reversal, and
// provides an immediate emergency stop. All outputs are registered.
module pwm_ramp_ctrl #(
    parameter int unsigned DUTY_W      = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input logic            ACLK,
    input logic            ARESETN,
    pwm_ramp_ctrl_if.slave ctrl
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        HOLD  = 3'd2,
        DOWN  = 3'd3,
        DEAD  = 3'd4,
        ESTOP = 3'd5
    } state_e;

    localparam int unsigned      DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                pwm_en_q, pwm_en_d;
    logic                busy_q, busy_d;
    logic                at_tgt_q, at_tgt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;

    logic                mismatch;
    logic                tick;
    logic [DUTY_W-1:0]   step_eff;
    logic [DUTY_W:0]     up_sum;
    logic [DUTY_W-1:0]   duty_up;
    logic [DUTY_W-1:0]   duty_dn_tgt;
    logic [DUTY_W-1:0]   duty_toward;
    logic [DUTY_W-1:0]   duty_to_zero;

    assign mismatch = (ctrl.target_dir != dir_q);
    assign tick     = (div_cnt_q >= ctrl.cfg_div);
    assign step_eff = (ctrl.cfg_step == '0) ? {{(DUTY_W-1){1'b0}}, 1'b1} : ctrl.cfg_step;

    // Upward step uses one extra bit so a large step cannot wrap past full scale;
    // both directions clamp at the target instead of overshooting it.
    assign up_sum       = {1'b0, duty_q} + {1'b0, step_eff};
    assign duty_up      = (up_sum >= {1'b0, ctrl.target_duty}) ? ctrl.target_duty : up_sum[DUTY_W-1:0];
    assign duty_dn_tgt  = ((duty_q - ctrl.target_duty) <= step_eff) ? ctrl.target_duty : (duty_q - step_eff);
    assign duty_toward  = (duty_q < ctrl.target_duty) ? duty_up : duty_dn_tgt;
    assign duty_to_zero = (duty_q <= step_eff) ? '0 : (duty_q - step_eff);

    // State and registered outputs; reset clears everything with no ramp-down.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            pwm_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            at_tgt_q   <= 1'b0;
            div_cnt_q  <= '0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            pwm_en_q   <= pwm_en_d;
            busy_q     <= busy_d;
            at_tgt_q   <= at_tgt_d;
            div_cnt_q  <= div_cnt_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    // Next-state decision: estop, then enable=0, then direction mismatch, then target change.
    always_comb begin
        state_d = state_q;
        if (ctrl.estop) begin
            state_d = ESTOP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl.enable) state_d = mismatch ? DEAD : RAMP;
                end
                RAMP: begin
                    if (!ctrl.enable || mismatch)       state_d = DOWN;
                    else if (duty_q == ctrl.target_duty) state_d = HOLD;
                end
                HOLD: begin
                    if (!ctrl.enable || mismatch)       state_d = DOWN;
                    else if (duty_q != ctrl.target_duty) state_d = RAMP;
                end
                DOWN: begin
                    if (!ctrl.enable) begin
                        if (duty_q == '0) state_d = IDLE;
                    end else if (mismatch) begin
                        if (duty_q == '0) state_d = DEAD;
                    end else begin
                        state_d = RAMP;
                    end
                end
                DEAD: begin
                    if (!ctrl.enable)                  state_d = IDLE;
                    else if (dead_cnt_q == DEAD_LAST)  state_d = RAMP;
                end
                ESTOP: begin
                    if (!ctrl.enable) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/datapath values for the state being entered; counters restart on state entry.
    always_comb begin
        duty_d     = duty_q;
        dir_d      = dir_q;
        div_cnt_d  = '0;
        dead_cnt_d = '0;
        case (state_d)
            RAMP: begin
                if (state_q == RAMP) begin
                    div_cnt_d = tick ? '0 : (div_cnt_q + 1'b1);
                    if (tick) duty_d = duty_toward;
                end
            end
            DOWN: begin
                if (state_q == DOWN) begin
                    div_cnt_d = tick ? '0 : (div_cnt_q + 1'b1);
                    if (tick) duty_d = duty_to_zero;
                end
            end
            HOLD: begin
                duty_d = duty_q;
            end
            DEAD: begin
                duty_d = '0;
                if (state_q == DEAD) dead_cnt_d = dead_cnt_q + 1'b1;
            end
            default: begin
                duty_d = '0;
            end
        endcase
        if (state_q == DEAD && state_d == RAMP) dir_d = ctrl.target_dir;
        pwm_en_d = (state_d == RAMP) || (state_d == HOLD) || (state_d == DOWN);
        busy_d   = (state_d == RAMP) || (state_d == DOWN) || (state_d == DEAD);
        at_tgt_d = (state_d == HOLD);
    end

    assign ctrl.duty_out  = duty_q;
    assign ctrl.dir_out   = dir_q;
    assign ctrl.pwm_en    = pwm_en_q;
    assign ctrl.busy      = busy_q;
    assign ctrl.at_target = at_tgt_q;
    assign ctrl.state     = state_q;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with hand-computed expected values.
module tb_pwm_ramp_ctrl;
    logic ACLK;
    logic ARESETN;
    int   n_checks;
    int   n_fail;

    pwm_ramp_ctrl_if #(.DUTY_W(16), .DIV_W(16)) bus ();

    pwm_ramp_ctrl #(.DUTY_W(16), .DIV_W(16), .DEAD_CYCLES(10)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .ctrl    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic clk(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset;
        bus.enable = 0; bus.estop = 0; bus.target_duty = 0; bus.target_dir = 0;
        bus.cfg_step = 0; bus.cfg_div = 0;
        ARESETN = 0;
        #12;
        n_checks++; if (bus.duty_out !== 16'd0)  begin n_fail++; $display("FAIL rst_duty: got %0d expected 0", bus.duty_out); end
        n_checks++; if (bus.dir_out !== 1'b0)    begin n_fail++; $display("FAIL rst_dir: got %0d expected 0", bus.dir_out); end
        n_checks++; if (bus.pwm_en !== 1'b0)     begin n_fail++; $display("FAIL rst_pwm_en: got %0d expected 0", bus.pwm_en); end
        n_checks++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %0d expected 0", bus.busy); end
        n_checks++; if (bus.at_target !== 1'b0)  begin n_fail++; $display("FAIL rst_at_target: got %0d expected 0", bus.at_target); end
        n_checks++; if (bus.state !== 3'd0)      begin n_fail++; $display("FAIL rst_state: got %0d expected 0", bus.state); end
        ARESETN = 1;
        clk(2);
        n_checks++; if (bus.state !== 3'd0)      begin n_fail++; $display("FAIL idle_state: got %0d expected 0", bus.state); end
    endtask

    task automatic test_ramp_up;
        int exp_d[3];
        exp_d = '{100, 200, 250};
        bus.cfg_div = 3; bus.cfg_step = 100; bus.target_duty = 250; bus.target_dir = 0; bus.enable = 1;
        clk(1);
        n_checks++; if (bus.state !== 3'd1)  begin n_fail++; $display("FAIL up_entry_state: got %0d expected 1", bus.state); end
        n_checks++; if (bus.pwm_en !== 1'b1) begin n_fail++; $display("FAIL up_entry_pwm_en: got %0d expected 1", bus.pwm_en); end
        n_checks++; if (bus.busy !== 1'b1)   begin n_fail++; $display("FAIL up_entry_busy: got %0d expected 1", bus.busy); end
        clk(3);
        n_checks++; if (bus.duty_out !== 16'd0) begin n_fail++; $display("FAIL up_no_early_tick: got %0d expected 0", bus.duty_out); end
        for (int i = 0; i < 3; i++) begin
            clk((i == 0) ? 1 : 4);
            n_checks++; if (bus.duty_out !== 16'(exp_d[i])) begin n_fail++; $display("FAIL up_duty[%0d]: got %0d expected %0d", i, bus.duty_out, exp_d[i]); end
            n_checks++; if (bus.pwm_en !== 1'b1) begin n_fail++; $display("FAIL up_pwm_en[%0d]: got %0d expected 1", i, bus.pwm_en); end
        end
        n_checks++; if (bus.at_target !== 1'b0) begin n_fail++; $display("FAIL up_at_target_early: got %0d expected 0", bus.at_target); end
        clk(1);
        n_checks++; if (bus.state !== 3'd2)      begin n_fail++; $display("FAIL up_hold_state: got %0d expected 2", bus.state); end
        n_checks++; if (bus.at_target !== 1'b1)  begin n_fail++; $display("FAIL up_at_target: got %0d expected 1", bus.at_target); end
        n_checks++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL up_hold_busy: got %0d expected 0", bus.busy); end
    endtask

    task automatic test_ramp_down_target;
        int exp_d[3];
        exp_d = '{150, 50, 0};
        bus.target_duty = 0;
        clk(1);
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL dn_tgt_state: got %0d expected 1", bus.state); end
        for (int i = 0; i < 3; i++) begin
            clk(4);
            n_checks++; if (bus.duty_out !== 16'(exp_d[i])) begin n_fail++; $display("FAIL dn_tgt_duty[%0d]: got %0d expected %0d", i, bus.duty_out, exp_d[i]); end
        end
        clk(1);
        n_checks++; if (bus.state !== 3'd2)  begin n_fail++; $display("FAIL dn_tgt_hold: got %0d expected 2", bus.state); end
        n_checks++; if (bus.pwm_en !== 1'b1) begin n_fail++; $display("FAIL dn_tgt_pwm_en: got %0d expected 1", bus.pwm_en); end
        bus.target_duty = 250;
        clk(13);
        n_checks++; if (bus.duty_out !== 16'd250) begin n_fail++; $display("FAIL reup_duty: got %0d expected 250", bus.duty_out); end
        clk(1);
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL reup_hold: got %0d expected 2", bus.state); end
    endtask

    task automatic test_reversal;
        int exp_d[3];
        exp_d = '{150, 50, 0};
        bus.target_dir = 1;
        clk(1);
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL rev_down_state: got %0d expected 3", bus.state); end
        for (int i = 0; i < 3; i++) begin
            clk(4);
            n_checks++; if (bus.duty_out !== 16'(exp_d[i])) begin n_fail++; $display("FAIL rev_duty[%0d]: got %0d expected %0d", i, bus.duty_out, exp_d[i]); end
        end
        clk(1);
        n_checks++; if (bus.state !== 3'd4)  begin n_fail++; $display("FAIL rev_dead_state: got %0d expected 4", bus.state); end
        n_checks++; if (bus.pwm_en !== 1'b0) begin n_fail++; $display("FAIL rev_dead_pwm_en: got %0d expected 0", bus.pwm_en); end
        clk(9);
        n_checks++; if (bus.state !== 3'd4)  begin n_fail++; $display("FAIL rev_dead_len: got %0d expected 4", bus.state); end
        n_checks++; if (bus.dir_out !== 1'b0) begin n_fail++; $display("FAIL rev_dir_early: got %0d expected 0", bus.dir_out); end
        clk(1);
        n_checks++; if (bus.state !== 3'd1)   begin n_fail++; $display("FAIL rev_ramp_state: got %0d expected 1", bus.state); end
        n_checks++; if (bus.dir_out !== 1'b1) begin n_fail++; $display("FAIL rev_dir: got %0d expected 1", bus.dir_out); end
        clk(12);
        n_checks++; if (bus.duty_out !== 16'd250) begin n_fail++; $display("FAIL rev_reup_duty: got %0d expected 250", bus.duty_out); end
        clk(1);
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL rev_hold: got %0d expected 2", bus.state); end
    endtask

    task automatic test_reversal_cancel;
        logic saw_dead;
        saw_dead = 1'b0;
        bus.target_dir = 0;
        clk(5);
        n_checks++; if (bus.duty_out !== 16'd150) begin n_fail++; $display("FAIL cancel_down_duty: got %0d expected 150", bus.duty_out); end
        bus.target_dir = 1;
        clk(1);
        n_checks++; if (bus.state !== 3'd1)   begin n_fail++; $display("FAIL cancel_ramp_state: got %0d expected 1", bus.state); end
        n_checks++; if (bus.dir_out !== 1'b1) begin n_fail++; $display("FAIL cancel_dir: got %0d expected 1", bus.dir_out); end
        for (int i = 0; i < 5; i++) begin
            clk(1);
            if (bus.state === 3'd4) saw_dead = 1'b1;
        end
        n_checks++; if (bus.duty_out !== 16'd250) begin n_fail++; $display("FAIL cancel_duty: got %0d expected 250", bus.duty_out); end
        n_checks++; if (bus.state !== 3'd2)       begin n_fail++; $display("FAIL cancel_hold: got %0d expected 2", bus.state); end
        n_checks++; if (saw_dead !== 1'b0)        begin n_fail++; $display("FAIL cancel_no_dead: got %0d expected 0", saw_dead); end
    endtask

    task automatic test_enable_off;
        bus.enable = 0;
        clk(1);
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL off_down: got %0d expected 3", bus.state); end
        clk(12);
        n_checks++; if (bus.duty_out !== 16'd0) begin n_fail++; $display("FAIL off_duty: got %0d expected 0", bus.duty_out); end
        clk(1);
        n_checks++; if (bus.state !== 3'd0)   begin n_fail++; $display("FAIL off_idle: got %0d expected 0", bus.state); end
        n_checks++; if (bus.dir_out !== 1'b1) begin n_fail++; $display("FAIL off_dir_kept: got %0d expected 1", bus.dir_out); end
        n_checks++; if (bus.pwm_en !== 1'b0)  begin n_fail++; $display("FAIL off_pwm_en: got %0d expected 0", bus.pwm_en); end
    endtask

    task automatic test_estop;
        bus.enable = 1;
        clk(9);
        n_checks++; if (bus.duty_out !== 16'd200) begin n_fail++; $display("FAIL es_pre_duty: got %0d expected 200", bus.duty_out); end
        bus.estop = 1;
        clk(1);
        bus.estop = 0;
        n_checks++; if (bus.state !== 3'd5)      begin n_fail++; $display("FAIL es_state: got %0d expected 5", bus.state); end
        n_checks++; if (bus.duty_out !== 16'd0)  begin n_fail++; $display("FAIL es_duty: got %0d expected 0", bus.duty_out); end
        n_checks++; if (bus.pwm_en !== 1'b0)     begin n_fail++; $display("FAIL es_pwm_en: got %0d expected 0", bus.pwm_en); end
        clk(3);
        n_checks++; if (bus.state !== 3'd5)      begin n_fail++; $display("FAIL es_latched: got %0d expected 5", bus.state); end
        bus.enable = 0;
        clk(1);
        n_checks++; if (bus.state !== 3'd0)      begin n_fail++; $display("FAIL es_exit: got %0d expected 0", bus.state); end
    endtask

    task automatic test_step_zero;
        bus.cfg_step = 0; bus.cfg_div = 0; bus.target_duty = 5; bus.enable = 1;
        clk(1);
        for (int k = 1; k <= 5; k++) begin
            clk(1);
            n_checks++; if (bus.duty_out !== 16'(k)) begin n_fail++; $display("FAIL step0_duty[%0d]: got %0d expected %0d", k, bus.duty_out, k); end
        end
        clk(1);
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL step0_hold: got %0d expected 2", bus.state); end
        bus.enable = 0;
        clk(10);
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL step0_idle: got %0d expected 0", bus.state); end
    endtask

    task automatic test_saturate;
        bus.cfg_step = 40000; bus.cfg_div = 0; bus.target_duty = 16'hFFFF; bus.enable = 1;
        clk(2);
        n_checks++; if (bus.duty_out !== 16'd40000) begin n_fail++; $display("FAIL sat_first: got %0d expected 40000", bus.duty_out); end
        clk(1);
        n_checks++; if (bus.duty_out !== 16'd65535) begin n_fail++; $display("FAIL sat_clamp: got %0d expected 65535", bus.duty_out); end
        clk(1);
        n_checks++; if (bus.state !== 3'd2)         begin n_fail++; $display("FAIL sat_hold: got %0d expected 2", bus.state); end
        n_checks++; if (bus.duty_out !== 16'd65535) begin n_fail++; $display("FAIL sat_no_wrap: got %0d expected 65535", bus.duty_out); end
        bus.enable = 0;
        clk(4);
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL sat_idle: got %0d expected 0", bus.state); end
    endtask

    task automatic test_async_reset;
        bus.cfg_step = 100; bus.cfg_div = 3; bus.target_duty = 250; bus.target_dir = 0; bus.enable = 1;
        clk(1);
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL ar_dead: got %0d expected 4", bus.state); end
        clk(3);
        #2 ARESETN = 0;
        #1;
        n_checks++; if (bus.state !== 3'd0)     begin n_fail++; $display("FAIL ar_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.dir_out !== 1'b0)   begin n_fail++; $display("FAIL ar_dir: got %0d expected 0", bus.dir_out); end
        n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL ar_busy: got %0d expected 0", bus.busy); end
        n_checks++; if (bus.duty_out !== 16'd0) begin n_fail++; $display("FAIL ar_duty: got %0d expected 0", bus.duty_out); end
        n_checks++; if (bus.pwm_en !== 1'b0)    begin n_fail++; $display("FAIL ar_pwm_en: got %0d expected 0", bus.pwm_en); end
        bus.enable = 0;
        #2 ARESETN = 1;
        clk(1);
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL ar_after: got %0d expected 0", bus.state); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ramp_up();
        test_ramp_down_target();
        test_reversal();
        test_reversal_cancel();
        test_enable_off();
        test_estop();
        test_step_zero();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
